du_cmd_engine: RTL and testbench

//  Parametrised debug-unit core between the PC byte link (UART rx/tx) and the MIPS pipeline.

---
 rtl/du_pkg.sv | 30 +++
 rtl/du_if.sv | 22 ++
 rtl/du_word_serializer.sv | 53 +++++
 rtl/du_cmd_engine.sv | 277 +++++++++++++++++++++++++++
 tb/tb_du_cmd_engine.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/du_pkg.sv
// Shared definitions for the debug-unit command engine.
//   - Command byte values received from the PC link.
//   - FSM state encoding and the dump sub-sequencer phase encoding.
package du_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h6C;  // 'l'
    localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_NEXT = 8'h0A;  // '\n'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
    localparam logic [7:0] CMD_QUIT = 8'h71;  // 'q'

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DUMP = 3'd4
    } du_state_e;

    // Per dumped word: issue read address, wait for the memory, capture into
    // the serializer; DRAIN waits for the last byte to leave.
    typedef enum logic [1:0] {
        DP_ADDR  = 2'd0,
        DP_WAIT  = 2'd1,
        DP_CAP   = 2'd2,
        DP_DRAIN = 2'd3
    } du_dump_phase_e;

endpackage

// File: rtl/du_if.sv
// Byte link between the PC-side UART and the debug unit.
//   rx_data/rx_valid : received byte, one-cycle strobe per byte
//   tx_data/tx_valid : byte to send, held until tx_ready accepts it
//   tx_ready         : transmitter accepts on the rising edge when tx_valid & tx_ready
// master = PC/UART side, slave = debug unit.
interface du_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/du_word_serializer.sv
// Sends one NB_DATA word as NB_BYTES bytes, LSB first, over a valid/ready link.
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   load_i, word_i  : word accepted when load_i is high and the block is idle
//   busy_o          : high while any byte of the current word is pending
//   tx_data_o       : current byte (registered)
//   tx_valid_o      : byte pending; held until tx_ready_i accepts it
//   tx_ready_i      : link accepts the byte on the rising edge
module du_word_serializer #(
    parameter int NB_DATA = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_i,
    output logic               busy_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i
);
    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [NB_DATA-1:0] word_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (!valid_q) begin
            if (load_i) begin
                word_q  <= word_i;
                cnt_q   <= '0;
                valid_q <= 1'b1;
            end
        end else if (tx_ready_i) begin
            if (cnt_q == NB_CNT'(NB_BYTES - 1)) begin
                valid_q <= 1'b0;
            end else begin
                word_q <= word_q >> 8;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign tx_data_o  = word_q[7:0];
    assign tx_valid_o = valid_q;
    assign busy_o     = valid_q;

endmodule

// File: rtl/du_cmd_engine.sv
// Debug-unit core between the PC byte link and the MIPS pipeline.
// Decodes command bytes, loads program memory from a little-endian byte
// stream, runs the CPU in continue or step mode and dumps PC, register bank
// and data memory back to the PC, LSB first.
// Optional feature macro: DU_CYCLE_CNT_EN -- adds an NB_DATA cycle counter
// (runs while o_cpu_en, cleared on 'c'/'s' from IDLE) sent as the last dump word.
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   link                 : PC byte link (rx strobe in, tx valid/ready out)
//   o_pmem_wr_en/addr/data : program-memory write port
//   o_rb_rd_addr, i_rb_rd_data : register-bank read (data one cycle after address)
//   o_dm_rd_addr, i_dm_rd_data : data-memory read (data one cycle after address)
//   i_if_pc, i_if_halt   : current PC and HALT-reached level
//   o_cpu_en             : pipeline clock-enable
module du_cmd_engine
    import du_pkg::*;
#(
    parameter int  NB_DATA      = 32,
    parameter int  N_PMEM_WORDS = 64,
    parameter int  N_REGS       = 32,
    parameter int  N_DMEM_WORDS = 64,
    parameter int  HALT_BIT     = 30,
    localparam int NB_PMEM_ADDR = $clog2(N_PMEM_WORDS),
    localparam int NB_REG_ADDR  = $clog2(N_REGS),
    localparam int NB_DMEM_ADDR = $clog2(N_DMEM_WORDS)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    du_if.slave                     link,
    output logic                    o_pmem_wr_en,
    output logic [NB_PMEM_ADDR-1:0] o_pmem_addr,
    output logic [NB_DATA-1:0]      o_pmem_data,
    output logic [NB_REG_ADDR-1:0]  o_rb_rd_addr,
    input  logic [NB_DATA-1:0]      i_rb_rd_data,
    output logic [NB_DMEM_ADDR-1:0] o_dm_rd_addr,
    input  logic [NB_DATA-1:0]      i_dm_rd_data,
    input  logic [NB_DATA-1:0]      i_if_pc,
    input  logic                    i_if_halt,
    output logic                    o_cpu_en
);
    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
`ifdef DU_CYCLE_CNT_EN
    localparam int N_ITEMS  = 1 + N_REGS + N_DMEM_WORDS + 1;
`else
    localparam int N_ITEMS  = 1 + N_REGS + N_DMEM_WORDS;
`endif
    localparam int NB_ITEM  = $clog2(N_ITEMS + 1);

    du_state_e              state_q;
    du_dump_phase_e         phase_q;
    logic                   ret_step_q;
    logic [NB_ITEM-1:0]     item_q;
    logic [NB_BCNT-1:0]     byte_cnt_q;
    logic [NB_DATA-1:0]     asm_q;
    logic [NB_PMEM_ADDR-1:0] load_addr_q;
    logic                   pmem_wr_en_q;
    logic [NB_PMEM_ADDR-1:0] pmem_addr_q;
    logic [NB_DATA-1:0]     pmem_data_q;
    logic [NB_REG_ADDR-1:0] rb_addr_q;
    logic [NB_DMEM_ADDR-1:0] dm_addr_q;
    logic                   cpu_en_q;
    logic                   ser_load_q;
    logic [NB_DATA-1:0]     ser_word_q;
    logic                   ser_busy;
`ifdef DU_CYCLE_CNT_EN
    logic [NB_DATA-1:0]     cyc_cnt_q;
`endif

    logic [NB_DATA-1:0]     asm_word_d;
    logic [NB_DATA-1:0]     cap_word_d;
    logic                   is_reg_d;
    logic                   is_dm_d;
    logic                   ser_idle_d;

    // Incoming load byte merged into the partially assembled word.
    always_comb begin
        asm_word_d = asm_q;
        for (int b = 0; b < NB_BYTES; b++) begin
            if (byte_cnt_q == NB_BCNT'(b)) begin
                asm_word_d[b*8 +: 8] = link.rx_data;
            end
        end
    end

    // Dump item order: 0 = PC, then registers, then data memory [, counter].
    always_comb begin
        is_reg_d   = (item_q != '0) && (item_q <= NB_ITEM'(N_REGS));
        is_dm_d    = (item_q > NB_ITEM'(N_REGS)) &&
                     (item_q <= NB_ITEM'(N_REGS + N_DMEM_WORDS));
        cap_word_d = i_if_pc;
        if (is_reg_d) begin
            cap_word_d = i_rb_rd_data;
        end else if (is_dm_d) begin
            cap_word_d = i_dm_rd_data;
        end
`ifdef DU_CYCLE_CNT_EN
        else if (item_q == NB_ITEM'(N_ITEMS - 1)) begin
            cap_word_d = cyc_cnt_q;
        end
`endif
    end

    // The load strobe is registered, so the serializer only shows busy one
    // cycle later; both must be clear before the next word or the dump end.
    assign ser_idle_d = !ser_busy && !ser_load_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= DP_ADDR;
            ret_step_q   <= 1'b0;
            item_q       <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            load_addr_q  <= '0;
            pmem_wr_en_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_data_q  <= '0;
            rb_addr_q    <= '0;
            dm_addr_q    <= '0;
            cpu_en_q     <= 1'b0;
            ser_load_q   <= 1'b0;
            ser_word_q   <= '0;
`ifdef DU_CYCLE_CNT_EN
            cyc_cnt_q    <= '0;
`endif
        end else begin
            pmem_wr_en_q <= 1'b0;
            ser_load_q   <= 1'b0;
`ifdef DU_CYCLE_CNT_EN
            if (cpu_en_q) begin
                cyc_cnt_q <= cyc_cnt_q + 1'b1;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (link.rx_valid) begin
                        case (link.rx_data)
                            CMD_LOAD: begin
                                state_q     <= ST_LOAD;
                                load_addr_q <= '0;
                                byte_cnt_q  <= '0;
                                asm_q       <= '0;
                            end
                            CMD_CONT: begin
                                state_q  <= ST_RUN;
                                cpu_en_q <= 1'b1;
`ifdef DU_CYCLE_CNT_EN
                                cyc_cnt_q <= '0;
`endif
                            end
                            CMD_STEP: begin
                                state_q <= ST_STEP;
`ifdef DU_CYCLE_CNT_EN
                                cyc_cnt_q <= '0;
`endif
                            end
                            CMD_DUMP: begin
                                state_q    <= ST_DUMP;
                                phase_q    <= DP_ADDR;
                                item_q     <= '0;
                                ret_step_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (link.rx_valid) begin
                        asm_q <= asm_word_d;
                        if (byte_cnt_q == NB_BCNT'(NB_BYTES - 1)) begin
                            byte_cnt_q   <= '0;
                            pmem_wr_en_q <= 1'b1;
                            pmem_addr_q  <= load_addr_q;
                            pmem_data_q  <= asm_word_d;
                            load_addr_q  <= load_addr_q + 1'b1;
                            // Last slot ends the load too: the address never wraps.
                            if (asm_word_d[HALT_BIT] ||
                                load_addr_q == NB_PMEM_ADDR'(N_PMEM_WORDS - 1)) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (i_if_halt) begin
                        cpu_en_q   <= 1'b0;
                        state_q    <= ST_DUMP;
                        phase_q    <= DP_ADDR;
                        item_q     <= '0;
                        ret_step_q <= 1'b0;
                    end
                end

                ST_STEP: begin
                    if (link.rx_valid) begin
                        if (link.rx_data == CMD_NEXT) begin
                            // Pulse lasts the first DUMP cycle, cleared there.
                            cpu_en_q   <= 1'b1;
                            state_q    <= ST_DUMP;
                            phase_q    <= DP_ADDR;
                            item_q     <= '0;
                            ret_step_q <= 1'b1;
                        end else if (link.rx_data == CMD_QUIT) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_DUMP: begin
                    cpu_en_q <= 1'b0;
                    case (phase_q)
                        DP_ADDR: begin
                            if (is_reg_d) begin
                                rb_addr_q <= NB_REG_ADDR'(item_q - NB_ITEM'(1));
                            end
                            if (is_dm_d) begin
                                dm_addr_q <= NB_DMEM_ADDR'(item_q - NB_ITEM'(1 + N_REGS));
                            end
                            phase_q <= DP_WAIT;
                        end
                        DP_WAIT: begin
                            phase_q <= DP_CAP;
                        end
                        DP_CAP: begin
                            if (ser_idle_d) begin
                                ser_word_q <= cap_word_d;
                                ser_load_q <= 1'b1;
                                if (item_q == NB_ITEM'(N_ITEMS - 1)) begin
                                    phase_q <= DP_DRAIN;
                                end else begin
                                    item_q  <= item_q + 1'b1;
                                    phase_q <= DP_ADDR;
                                end
                            end
                        end
                        DP_DRAIN: begin
                            if (ser_idle_d) begin
                                phase_q <= DP_ADDR;
                                state_q <= (ret_step_q && !i_if_halt) ? ST_STEP : ST_IDLE;
                            end
                        end
                        default: phase_q <= DP_ADDR;
                    endcase
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    du_word_serializer #(
        .NB_DATA (NB_DATA)
    ) u_ser (
        .clk_i      (i_clk),
        .rst_i      (i_reset),
        .load_i     (ser_load_q),
        .word_i     (ser_word_q),
        .busy_o     (ser_busy),
        .tx_data_o  (link.tx_data),
        .tx_valid_o (link.tx_valid),
        .tx_ready_i (link.tx_ready)
    );

    assign o_pmem_wr_en = pmem_wr_en_q;
    assign o_pmem_addr  = pmem_addr_q;
    assign o_pmem_data  = pmem_data_q;
    assign o_rb_rd_addr = rb_addr_q;
    assign o_dm_rd_addr = dm_addr_q;
    assign o_cpu_en     = cpu_en_q;

endmodule

// File: tb/tb_du_cmd_engine.sv
// Scoreboard bench for du_cmd_engine (default parameters).
module tb_du_cmd_engine;
    localparam logic [31:0] PC_VAL = 32'h9999_9999;
`ifdef DU_CYCLE_CNT_EN
    localparam int N_WORDS = 1 + 32 + 64 + 1;
`else
    localparam int N_WORDS = 1 + 32 + 64;
`endif
    localparam int DUMP_BYTES = 4 * N_WORDS;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [5:0]  pmem_addr;
    logic [31:0] pmem_data;
    logic [4:0]  rb_addr;
    logic [31:0] rb_data;
    logic [5:0]  dm_addr;
    logic [31:0] dm_data;
    logic [31:0] if_pc;
    logic        if_halt;
    logic        cpu_en;

    logic [31:0] regs [32];
    logic [31:0] dmem [64];

    logic [7:0]  exp_tx [$];
    logic [63:0] exp_wr [$];

    int n_checks;
    int n_fail;
    int tx_total;
    int en_total;
`ifdef DU_CYCLE_CNT_EN
    logic [31:0] exp_cyc;
`endif

    du_if link ();

    du_cmd_engine dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .link         (link),
        .o_pmem_wr_en (wr_en),
        .o_pmem_addr  (pmem_addr),
        .o_pmem_data  (pmem_data),
        .o_rb_rd_addr (rb_addr),
        .i_rb_rd_data (rb_data),
        .o_dm_rd_addr (dm_addr),
        .i_dm_rd_data (dm_data),
        .i_if_pc      (if_pc),
        .i_if_halt    (if_halt),
        .o_cpu_en     (cpu_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data follows the address one cycle later.
    always @(posedge clk) begin
        rb_data <= regs[rb_addr];
        dm_data <= dmem[dm_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_tx();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (link.tx_valid && link.tx_ready) begin
                tx_total++;
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", {56'd0, link.tx_data}, 64'hFFFF);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", {56'd0, link.tx_data}, {56'd0, e});
                end
            end
        end
    endtask

    task automatic mon_wr();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {26'd0, pmem_addr, pmem_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    check("pmem_write", {26'd0, pmem_addr, pmem_data}, e);
                end
            end
        end
    endtask

    task automatic mon_en();
        forever begin
            @(negedge clk);
            if (cpu_en) en_total++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        link.rx_data  = b;
        link.rx_valid = 1'b1;
        @(posedge clk); #1;
        link.rx_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_tx.push_back(w[b*8 +: 8]);
    endtask

    task automatic push_dump();
        push_word(PC_VAL);
        for (int i = 0; i < 32; i++) push_word(32'd64 + i);
        for (int i = 0; i < 64; i++) push_word(32'hD000_0000 + i);
`ifdef DU_CYCLE_CNT_EN
        push_word(exp_cyc);
`endif
    endtask

    task automatic wait_dump(input string name, input int tx_before);
        for (int i = 0; i < 4000 && exp_tx.size() != 0; i++) @(posedge clk);
        check({name, "_done"}, 64'(exp_tx.size()), 64'd0);
        repeat (6) @(posedge clk);
        check({name, "_bytes"}, 64'(tx_total - tx_before), 64'(DUMP_BYTES));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_tx_valid"}, {63'd0, link.tx_valid}, 64'd0);
        check({name, "_tx_data"},  {56'd0, link.tx_data}, 64'd0);
        check({name, "_wr_en"},    {63'd0, wr_en}, 64'd0);
        check({name, "_pmem_addr"}, {58'd0, pmem_addr}, 64'd0);
        check({name, "_pmem_data"}, {32'd0, pmem_data}, 64'd0);
        check({name, "_rb_addr"},  {59'd0, rb_addr}, 64'd0);
        check({name, "_dm_addr"},  {58'd0, dm_addr}, 64'd0);
        check({name, "_cpu_en"},   {63'd0, cpu_en}, 64'd0);
    endtask

    initial begin
        int t0;
        int e0;
        logic [7:0] v1 [8];
        n_checks = 0; n_fail = 0; tx_total = 0; en_total = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd64 + i;
        for (int i = 0; i < 64; i++) dmem[i] = 32'hD000_0000 + i;
        rst = 1'b1;
        link.rx_data = 8'h00; link.rx_valid = 1'b0; link.tx_ready = 1'b1;
        if_pc = PC_VAL; if_halt = 1'b0;
`ifdef DU_CYCLE_CNT_EN
        exp_cyc = 32'd0;
`endif
        fork
            mon_tx();
            mon_wr();
            mon_en();
        join_none

        repeat (3) @(posedge clk); #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: two-word load ending on HALT; trailing bytes are not a third write.
        v1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h40};
        exp_wr.push_back({26'd0, 6'd0, 32'h1234_5678});
        exp_wr.push_back({26'd0, 6'd1, 32'h4000_0000});
        send_byte(8'h6C);
        for (int i = 0; i < 8; i++) send_byte(v1[i]);
        for (int i = 0; i < 4; i++) send_byte(8'h01);
        repeat (3) @(posedge clk);
        check("t1_writes_left", 64'(exp_wr.size()), 64'd0);

        // 2: full 64-word load without HALT, then 'l' is a fresh command.
        send_byte(8'h6C);
        for (int w = 0; w < 64; w++) begin
            exp_wr.push_back({26'd0, 6'(w), 32'(w)});
            send_byte(8'(w)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        exp_wr.push_back({26'd0, 6'd0, 32'h4000_0001});
        send_byte(8'h6C);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        repeat (3) @(posedge clk);
        check("t2_writes_left", 64'(exp_wr.size()), 64'd0);

        // 3: dump from IDLE.
        t0 = tx_total;
        push_dump();
        send_byte(8'h64);
        wait_dump("t3", t0);

        // 4: continue, halt sampled 10 cycles after the 'c' strobe.
        t0 = tx_total; e0 = en_total;
`ifdef DU_CYCLE_CNT_EN
        exp_cyc = 32'd10;
`endif
        push_dump();
        send_byte(8'h63);
        repeat (9) @(posedge clk); #1;
        if_halt = 1'b1;
        wait_dump("t4", t0);
        check("t4_cpu_en_cycles", 64'(en_total - e0), 64'd10);
        if_halt = 1'b0;

        // 5: step mode, three steps each with a dump, then quit.
        send_byte(8'h73);
        for (int k = 1; k <= 3; k++) begin
            t0 = tx_total; e0 = en_total;
`ifdef DU_CYCLE_CNT_EN
            exp_cyc = 32'(k);
`endif
            push_dump();
            send_byte(8'h0A);
            wait_dump("t5_step", t0);
            check("t5_pulse_cycles", 64'(en_total - e0), 64'd1);
        end
        send_byte(8'h71);
        t0 = tx_total; e0 = en_total;
        send_byte(8'h0A);
        repeat (10) @(posedge clk);
        check("t5_idle_no_pulse", 64'(en_total - e0), 64'd0);
        check("t5_idle_no_tx", 64'(tx_total - t0), 64'd0);

        // 6: stalled link mid-dump, then reset in the middle of a load.
        t0 = tx_total;
        push_dump();
        send_byte(8'h64);
        for (int i = 0; i < 2000 && exp_tx.size() > DUMP_BYTES - 37; i++) @(posedge clk);
        #1 link.tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        check("t6_stall_hold", {63'd0, link.tx_valid}, 64'd1);
        #1 link.tx_ready = 1'b1;
        wait_dump("t6", t0);

        send_byte(8'h6C);
        send_byte(8'h78);
        send_byte(8'h56);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.push_back({26'd0, 6'd0, 32'h4000_0000});
        send_byte(8'h6C);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        repeat (5) @(posedge clk);
        check("t6_writes_left", 64'(exp_wr.size()), 64'd0);
        check("end_tx_left", 64'(exp_tx.size()), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
